// File: rtl/synth_pkg.sv
// Shared widths, constants and envelope state encoding for the synth voice path.
package synth_pkg;

    localparam int SAMPLE_W = 32;
    localparam int LEVEL_W  = 16;

    localparam logic [LEVEL_W-1:0] ENV_FULL = 16'hFFFF;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Control, rate and sample signals between a voice controller and the ADSR envelope/VCA.
interface adsr_envelope_if;
    import synth_pkg::*;

    logic                       gate;
    logic                       tick;
    logic [LEVEL_W-1:0]         attack_rate;
    logic [LEVEL_W-1:0]         decay_rate;
    logic [LEVEL_W-1:0]         sustain_level;
    logic [LEVEL_W-1:0]         release_rate;
    logic signed [SAMPLE_W-1:0] in;
    logic signed [SAMPLE_W-1:0] out;
    logic [LEVEL_W-1:0]         level;
    logic                       active;

    modport master (
        output gate, tick, attack_rate, decay_rate, sustain_level, release_rate, in,
        input  out, level, active
    );

    modport slave (
        input  gate, tick, attack_rate, decay_rate, sustain_level, release_rate, in,
        output out, level, active
    );

endinterface

// File: rtl/envelope_vca.sv
// Registered signed VCA: out = floor(in * level / 65536), level treated as unsigned.
module envelope_vca
    import synth_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] in,
    input  logic [LEVEL_W-1:0]         level,
    output logic signed [SAMPLE_W-1:0] out
);

    // The 49-bit product's MSB always equals bit 47, so 48 bits hold it exactly.
    logic signed [SAMPLE_W+LEVEL_W-1:0] product;

    always_comb begin
        product = $signed({{LEVEL_W{in[SAMPLE_W-1]}}, in}) *
                  $signed({{SAMPLE_W{1'b0}}, level});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= product[SAMPLE_W+LEVEL_W-1:LEVEL_W];
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate edge detect, tick-driven level FSM, and the output VCA.
module adsr_envelope
    import synth_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    adsr_envelope_if.slave  bus
);

    env_state_t         state;
    logic [LEVEL_W-1:0] level_r;
    logic               active_r;
    logic               gate_q;

    logic               rise;
    logic               fall;
    logic [LEVEL_W:0]   att_sum;
    logic [LEVEL_W:0]   dec_floor;
    logic               att_full;
    logic               dec_done;
    logic               rel_done;

    always_comb begin
        rise      = bus.gate & ~gate_q;
        fall      = ~bus.gate & gate_q;
        att_sum   = {1'b0, level_r} + {1'b0, bus.attack_rate};
        dec_floor = {1'b0, bus.sustain_level} + {1'b0, bus.decay_rate};
        att_full  = att_sum >= {1'b0, ENV_FULL};
        dec_done  = {1'b0, level_r} <= dec_floor;
        rel_done  = level_r <= bus.release_rate;
    end

    // Any gate edge consumes the cycle: a coincident tick is dropped, even when the edge is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENV_IDLE;
            level_r  <= '0;
            active_r <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            gate_q <= bus.gate;
            if (rise || fall) begin
                if (rise && (state == ENV_IDLE || state == ENV_RELEASE)) begin
                    state    <= ENV_ATTACK;
                    active_r <= 1'b1;
                end else if (fall && (state == ENV_ATTACK || state == ENV_DECAY ||
                                      state == ENV_SUSTAIN)) begin
                    state    <= ENV_RELEASE;
                    active_r <= 1'b1;
                end
            end else if (bus.tick) begin
                unique case (state)
                    ENV_IDLE: begin
                        level_r <= '0;
                    end
                    ENV_ATTACK: begin
                        if (att_full) begin
                            level_r <= ENV_FULL;
                            state   <= ENV_DECAY;
                        end else begin
                            level_r <= att_sum[LEVEL_W-1:0];
                        end
                    end
                    ENV_DECAY: begin
                        if (dec_done) begin
                            level_r <= bus.sustain_level;
                            state   <= ENV_SUSTAIN;
                        end else begin
                            level_r <= level_r - bus.decay_rate;
                        end
                    end
                    ENV_SUSTAIN: begin
                        level_r <= bus.sustain_level;
                    end
                    ENV_RELEASE: begin
                        if (rel_done) begin
                            level_r  <= '0;
                            state    <= ENV_IDLE;
                            active_r <= 1'b0;
                        end else begin
                            level_r <= level_r - bus.release_rate;
                        end
                    end
                    default: begin
                        level_r  <= '0;
                        state    <= ENV_IDLE;
                        active_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.level  = level_r;
    assign bus.active = active_r;

    envelope_vca u_vca (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.in),
        .level (level_r),
        .out   (bus.out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed scoreboard bench for adsr_envelope: envelope phases, VCA scaling, edge/tick collisions, async reset.
module tb_adsr_envelope;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adsr_envelope_if bus();

    adsr_envelope dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {K_LEVEL, K_ACTIVE, K_STATE, K_OUT} kind_t;
    typedef struct {
        kind_t       kind;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_LEVEL:  return {16'b0, bus.level};
            K_ACTIVE: return {31'b0, bus.active};
            K_STATE:  return 32'(dut.state);
            default:  return bus.out;
        endcase
    endfunction

    function automatic logic [31:0] vca_model(logic [31:0] s, logic [15:0] l);
        longint p;
        p = longint'($signed(s)) * longint'({48'b0, l});
        return 32'(p >>> 16);
    endfunction

    task automatic push_exp(kind_t k, string tag, logic [31:0] e);
        exp_t x;
        x.kind = k;
        x.tag  = tag;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                       e.tag, obs, obs, e.exp, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(string tag, logic [15:0] lvl, env_state_t st);
        push_exp(K_LEVEL, {tag, "_lvl"}, {16'b0, lvl});
        push_exp(K_STATE, {tag, "_st"}, 32'(st));
        cyc();
        check_all();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.gate          = 1'b0;
        bus.tick          = 1'b0;
        bus.attack_rate   = 16'd16384;
        bus.decay_rate    = 16'd4096;
        bus.sustain_level = 16'd40000;
        bus.release_rate  = 16'd20000;
        bus.in            = 32'sh1234_5678;

        @(negedge clk);
        @(negedge clk);
        push_exp(K_LEVEL,  "rst_lvl", 32'd0);
        push_exp(K_ACTIVE, "rst_act", 32'd0);
        push_exp(K_OUT,    "rst_out", 32'd0);
        push_exp(K_STATE,  "rst_st",  32'(ENV_IDLE));
        check_all();

        // Ticks without a gate rise must leave the block idle.
        rst_n    = 1'b1;
        bus.tick = 1'b1;
        push_exp(K_OUT, "idle_out0", 32'd0);
        step("idle_tick1", 16'd0, ENV_IDLE);
        push_exp(K_ACTIVE, "idle_act", 32'd0);
        step("idle_tick2", 16'd0, ENV_IDLE);

        bus.tick = 1'b0;
        bus.gate = 1'b1;
        push_exp(K_ACTIVE, "rise_act", 32'd1);
        step("rise", 16'd0, ENV_ATTACK);

        bus.tick = 1'b1;
        step("att1", 16'd16384, ENV_ATTACK);
        step("att2", 16'd32768, ENV_ATTACK);
        step("att3", 16'd49152, ENV_ATTACK);
        step("att4", 16'd65535, ENV_DECAY);

        for (int i = 1; i <= 6; i++) begin
            step($sformatf("dec%0d", i), 16'(65535 - 4096 * i), ENV_DECAY);
        end
        step("dec7", 16'd40000, ENV_SUSTAIN);
        step("sus_hold", 16'd40000, ENV_SUSTAIN);
        bus.sustain_level = 16'd40001;
        step("sus_track", 16'd40001, ENV_SUSTAIN);
        bus.sustain_level = 16'd40000;
        step("sus_back", 16'd40000, ENV_SUSTAIN);

        bus.tick = 1'b0;
        bus.gate = 1'b0;
        step("fall", 16'd40000, ENV_RELEASE);
        bus.tick = 1'b1;
        step("rel1", 16'd20000, ENV_RELEASE);
        push_exp(K_ACTIVE, "rel2_act", 32'd0);
        step("rel2", 16'd0, ENV_IDLE);

        bus.tick = 1'b0;
        bus.in   = 32'sh7FFF_FFFF;
        push_exp(K_OUT, "vca_zero_lvl", 32'd0);
        cyc();
        check_all();

        // Bring level to full scale for the VCA checks.
        bus.gate        = 1'b1;
        bus.attack_rate = 16'hFFFF;
        step("rise2", 16'd0, ENV_ATTACK);
        bus.tick = 1'b1;
        step("att_full", 16'd65535, ENV_DECAY);
        bus.tick = 1'b0;

        bus.in = 32'sd65534;
        push_exp(K_OUT, "vca_pos", 32'd65533);
        cyc();
        check_all();
        bus.in = -32'sd65534;
        push_exp(K_OUT, "vca_neg", 32'hFFFF_0002);
        cyc();
        check_all();
        for (int i = 0; i < 3; i++) begin
            bus.in = $urandom;
            push_exp(K_OUT, $sformatf("vca_rand%0d", i), vca_model(bus.in, 16'hFFFF));
            cyc();
            check_all();
        end

        bus.gate = 1'b0;
        step("fall2", 16'd65535, ENV_RELEASE);
        bus.release_rate = 16'hFFFF;
        bus.tick         = 1'b1;
        step("rel_full", 16'd0, ENV_IDLE);
        bus.tick        = 1'b0;
        bus.attack_rate = 16'd16384;
        bus.gate        = 1'b1;
        step("rise3", 16'd0, ENV_ATTACK);
        bus.tick = 1'b1;
        step("att_a", 16'd16384, ENV_ATTACK);
        step("att_b", 16'd32768, ENV_ATTACK);

        bus.gate = 1'b0;
        step("coll_fall", 16'd32768, ENV_RELEASE);
        bus.release_rate = 16'd2768;
        step("coll_rel", 16'd30000, ENV_RELEASE);
        bus.gate = 1'b1;
        step("coll_rise", 16'd30000, ENV_ATTACK);
        step("legato1", 16'd46384, ENV_ATTACK);
        step("legato2", 16'd62768, ENV_ATTACK);
        step("legato3", 16'd65535, ENV_DECAY);
        step("legato4", 16'd61439, ENV_DECAY);

        bus.tick = 1'b0;
        bus.in   = 32'sd65534;
        push_exp(K_OUT, "pre_rst_out", vca_model(32'sd65534, 16'd61439));
        cyc();
        check_all();

        // Reset asserted between clock edges must clear outputs without a clock.
        #2;
        rst_n    = 1'b0;
        bus.gate = 1'b0;
        #1;
        push_exp(K_LEVEL,  "arst_lvl", 32'd0);
        push_exp(K_ACTIVE, "arst_act", 32'd0);
        push_exp(K_OUT,    "arst_out", 32'd0);
        push_exp(K_STATE,  "arst_st",  32'(ENV_IDLE));
        check_all();

        @(negedge clk);
        rst_n    = 1'b1;
        bus.tick = 1'b1;
        step("post_rst1", 16'd0, ENV_IDLE);
        push_exp(K_ACTIVE, "post_rst_act", 32'd0);
        step("post_rst2", 16'd0, ENV_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
